// File: rtl/bcd_pkg.sv
// ---------------------------------------------------------------------------
// bcd_pkg
// Shared types and helpers for the BCD counter slice.
//   bcd_digit_t    one packed BCD digit
//   BCD_MAX_DIGIT  largest legal digit value (9)
//   int_to_bcd     converts a decimal integer to packed BCD (up to 16 digits)
//   bcd_is_valid   true when every nibble of a packed vector is a legal digit
// ---------------------------------------------------------------------------
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX_DIGIT = 4'd9;

    // Used at elaboration time to turn the decimal window parameters into
    // packed BCD constants. Digits beyond 'digits' stay zero.
    function automatic logic [63:0] int_to_bcd(input int value, input int digits);
        logic [63:0] result;
        int          remaining;
        result    = '0;
        remaining = value;
        for (int i = 0; i < 16; i++) begin
            if (i < digits) begin
                result[4*i +: 4] = 4'(remaining % 10);
                remaining        = remaining / 10;
            end
        end
        return result;
    endfunction

    // Unused upper nibbles are expected to be zero-extended, which is legal BCD.
    function automatic logic bcd_is_valid(input logic [63:0] vec);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (vec[4*i +: 4] > BCD_MAX_DIGIT) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/bcd_digit_step.sv
// ---------------------------------------------------------------------------
// bcd_digit_step
// Steps a single BCD digit by one in either direction when cin_i is set.
// Chained LSD to MSD, cout_o of one digit feeds cin_i of the next.
//   digit_i   current digit
//   up_dn_i   1 = increment, 0 = decrement
//   cin_i     carry (up) or borrow (down) request from the lower digit
//   digit_o   stepped digit (equals digit_i when cin_i is low)
//   cout_o    carry/borrow out: digit rolled 9->0 (up) or 0->9 (down)
// ---------------------------------------------------------------------------
module bcd_digit_step
    import bcd_pkg::*;
(
    input  bcd_digit_t digit_i,
    input  logic       up_dn_i,
    input  logic       cin_i,
    output bcd_digit_t digit_o,
    output logic       cout_o
);

    // Only a requested step changes the digit; rollover produces the carry
    // (or borrow) that ripples into the next digit.
    always_comb begin
        digit_o = digit_i;
        cout_o  = 1'b0;
        if (cin_i) begin
            if (up_dn_i) begin
                if (digit_i >= BCD_MAX_DIGIT) begin
                    digit_o = 4'd0;
                    cout_o  = 1'b1;
                end else begin
                    digit_o = digit_i + 4'd1;
                end
            end else begin
                if (digit_i == 4'd0) begin
                    digit_o = BCD_MAX_DIGIT;
                    cout_o  = 1'b1;
                end else begin
                    digit_o = digit_i - 4'd1;
                end
            end
        end
    end

endmodule

// File: rtl/bcd_counter_n.sv
// ---------------------------------------------------------------------------
// bcd_counter_n
// N-digit BCD up/down counter confined to the window [MIN_VAL..MAX_VAL].
// Optional build macro: BCD_COUNTER_SATURATE_EN
//   defined   -> counter holds at the window edge, wrap never pulses
//   undefined -> counter wraps MAX->MIN / MIN->MAX and pulses wrap
// Ports:
//   clock       system clock, all state updates on posedge
//   reset       synchronous active-high reset to RESET_VAL
//   enable      step the count by one this cycle
//   up_dn       1 = up, 0 = down
//   load        synchronous load request (priority over enable)
//   load_value  BCD value to load, digit 0 in [3:0]
//   count       current BCD count, digit 0 in [3:0]
//   tc          combinational terminal count (chain into next enable)
//   wrap        registered one-cycle pulse on window wrap
//   load_err    registered one-cycle pulse on a rejected load
// ---------------------------------------------------------------------------
module bcd_counter_n
    import bcd_pkg::*;
#(
    parameter int DIGITS    = 2,
    parameter int MIN_VAL   = 1,
    parameter int MAX_VAL   = 99,
    parameter int RESET_VAL = MIN_VAL
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    input  logic                up_dn,
    input  logic                load,
    input  logic [4*DIGITS-1:0] load_value,
    output logic [4*DIGITS-1:0] count,
    output logic                tc,
    output logic                wrap,
    output logic                load_err
);

    localparam int W = 4 * DIGITS;

    localparam logic [63:0] MIN_BCD64   = int_to_bcd(MIN_VAL, DIGITS);
    localparam logic [63:0] MAX_BCD64   = int_to_bcd(MAX_VAL, DIGITS);
    localparam logic [63:0] RESET_BCD64 = int_to_bcd(RESET_VAL, DIGITS);

    localparam logic [W-1:0] MIN_BCD   = MIN_BCD64[W-1:0];
    localparam logic [W-1:0] MAX_BCD   = MAX_BCD64[W-1:0];
    localparam logic [W-1:0] RESET_BCD = RESET_BCD64[W-1:0];

    // Bad parameter sets must stop elaboration rather than build a counter
    // that could leave its window.
    if (DIGITS < 1 || DIGITS > 9) begin : g_chk_digits
        $fatal(1, "bcd_counter_n: DIGITS must be 1..9");
    end
    if (MIN_VAL < 0 || MIN_VAL > MAX_VAL) begin : g_chk_window
        $fatal(1, "bcd_counter_n: need 0 <= MIN_VAL <= MAX_VAL");
    end
    if (longint'(MAX_VAL) >= longint'(10) ** DIGITS) begin : g_chk_max
        $fatal(1, "bcd_counter_n: MAX_VAL does not fit in DIGITS");
    end
    if (RESET_VAL < MIN_VAL || RESET_VAL > MAX_VAL) begin : g_chk_reset
        $fatal(1, "bcd_counter_n: RESET_VAL outside window");
    end

    logic [W-1:0]    count_q, count_d;
    logic            wrap_q, wrap_d;
    logic            loadErr_q, loadErr_d;
    logic [W-1:0]    stepCount;
    logic [DIGITS:0] carry;
    logic            atMax, atMin, atEdge, loadOk;

    // Ripple chain of digit steppers; digit 0 always receives a step request.
    assign carry[0] = 1'b1;
    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit_step u_step (
            .digit_i (count_q[4*g +: 4]),
            .up_dn_i (up_dn),
            .cin_i   (carry[g]),
            .digit_o (stepCount[4*g +: 4]),
            .cout_o  (carry[g+1])
        );
    end

    // Valid BCD orders the same as its decimal value, so plain unsigned
    // compares work for the window. A carry/borrow out of the top digit can
    // only happen at a full-range edge and is treated as a window edge too.
    always_comb begin
        atMax  = (count_q == MAX_BCD);
        atMin  = (count_q == MIN_BCD);
        atEdge = (up_dn ? atMax : atMin) | carry[DIGITS];
        loadOk = bcd_is_valid(64'(load_value))
                 && (load_value >= MIN_BCD) && (load_value <= MAX_BCD);
    end

    // Next-state: load beats enable; a load cycle never reports wrap, and
    // a rejected load leaves the count untouched.
    always_comb begin
        count_d   = count_q;
        wrap_d    = 1'b0;
        loadErr_d = 1'b0;
        if (load) begin
            if (loadOk) begin
                count_d = load_value;
            end else begin
                loadErr_d = 1'b1;
            end
        end else if (enable) begin
            if (atEdge) begin
`ifdef BCD_COUNTER_SATURATE_EN
                count_d = count_q;
`else
                count_d = up_dn ? MIN_BCD : MAX_BCD;
                wrap_d  = 1'b1;
`endif
            end else begin
                count_d = stepCount;
            end
        end
    end

    // State register with synchronous reset taking priority over everything.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_q   <= RESET_BCD;
            wrap_q    <= 1'b0;
            loadErr_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            wrap_q    <= wrap_d;
            loadErr_q <= loadErr_d;
        end
    end

    // Terminal count is left unregistered so a chained stage sees it in the
    // same cycle it must step.
    assign tc       = enable & ((up_dn & atMax) | (~up_dn & atMin));
    assign count    = count_q;
    assign wrap     = wrap_q;
    assign load_err = loadErr_q;

endmodule

// File: tb/tb_bcd_counter_n.sv
// ---------------------------------------------------------------------------
// tb_bcd_counter_n
// Self-checking bench for bcd_counter_n with default parameters
// (2 digits, window 01..99, reset to 01). Honours BCD_COUNTER_SATURATE_EN.
// ---------------------------------------------------------------------------
module tb_bcd_counter_n;

`ifdef BCD_COUNTER_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic       clock;
    logic       reset;
    logic       enable;
    logic       up_dn;
    logic       load;
    logic [7:0] load_value;
    logic [7:0] count;
    logic       tc;
    logic       wrap;
    logic       load_err;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       rst;
        logic       en;
        logic       ud;
        logic       ld;
        logic [7:0] lv;
        logic [7:0] expCount;
        logic       expWrap;
        logic       expErr;
        logic       expTc;
    } vec_t;

    typedef struct {
        logic [7:0] c;
        logic       w;
        logic       e;
        int         idx;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    bcd_counter_n #(
        .DIGITS    (2),
        .MIN_VAL   (1),
        .MAX_VAL   (99),
        .RESET_VAL (1)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .up_dn      (up_dn),
        .load       (load),
        .load_value (load_value),
        .count      (count),
        .tc         (tc),
        .wrap       (wrap),
        .load_err   (load_err)
    );

    // Free-running 10-time-unit clock.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic void addVec(input logic rst, input logic en, input logic ud,
                                   input logic ld, input logic [7:0] lv,
                                   input logic [7:0] c, input logic w,
                                   input logic e, input logic t);
        vec_t v;
        v.rst = rst; v.en = en; v.ud = ud; v.ld = ld; v.lv = lv;
        v.expCount = c; v.expWrap = w; v.expErr = e; v.expTc = t;
        vecs.push_back(v);
    endfunction

    task automatic checkVal(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%02h expected=%02h", name, act, exp);
        end
    endtask

    // Drive one vector just after a falling edge, check the combinational tc
    // before the active edge and queue the registered expectations.
    task automatic applyStimulus(input vec_t v, input int idx);
        exp_t e;
        reset      = v.rst;
        enable     = v.en;
        up_dn      = v.ud;
        load       = v.ld;
        load_value = v.lv;
        #1;
        checkVal($sformatf("tc[%0d]", idx), {7'd0, tc}, {7'd0, v.expTc});
        e.c = v.expCount; e.w = v.expWrap; e.e = v.expErr; e.idx = idx;
        sb.push_back(e);
    endtask

    // Wait past the active edge, then pop the oldest expectation and compare.
    task automatic checkOutput();
        exp_t e;
        @(posedge clock);
        #1;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL scoreboard_empty actual=0 expected=1");
        end else begin
            e = sb.pop_front();
            checkVal($sformatf("count[%0d]", e.idx), count, e.c);
            checkVal($sformatf("wrap[%0d]", e.idx), {7'd0, wrap}, {7'd0, e.w});
            checkVal($sformatf("load_err[%0d]", e.idx), {7'd0, load_err}, {7'd0, e.e});
        end
        @(negedge clock);
    endtask

    task automatic runVec(input logic rst, input logic en, input logic ud,
                          input logic ld, input logic [7:0] lv,
                          input logic [7:0] c, input logic w,
                          input logic e, input logic t, input int idx);
        vec_t v;
        v.rst = rst; v.en = en; v.ud = ud; v.ld = ld; v.lv = lv;
        v.expCount = c; v.expWrap = w; v.expErr = e; v.expTc = t;
        applyStimulus(v, idx);
        checkOutput();
    endtask

    initial begin
        reset      = 1'b0;
        enable     = 1'b0;
        up_dn      = 1'b1;
        load       = 1'b0;
        load_value = 8'h00;

        //     rst en ud ld  lv     count             wrap      err  tc
        addVec(1, 0, 1, 0, 8'h00, 8'h01,            0,        0,   0);
        addVec(0, 1, 1, 0, 8'h00, 8'h02,            0,        0,   0);
        addVec(0, 1, 1, 0, 8'h00, 8'h03,            0,        0,   0);
        addVec(0, 1, 1, 0, 8'h00, 8'h04,            0,        0,   0);
        addVec(0, 1, 1, 0, 8'h00, 8'h05,            0,        0,   0);
        addVec(0, 1, 1, 0, 8'h00, 8'h06,            0,        0,   0);
        addVec(0, 1, 1, 0, 8'h00, 8'h07,            0,        0,   0);
        addVec(0, 1, 1, 0, 8'h00, 8'h08,            0,        0,   0);
        addVec(0, 1, 1, 0, 8'h00, 8'h09,            0,        0,   0);
        addVec(0, 1, 1, 0, 8'h00, 8'h10,            0,        0,   0);
        addVec(0, 0, 1, 1, 8'h99, 8'h99,            0,        0,   0);
        addVec(0, 1, 1, 0, 8'h00, SAT ? 8'h99 : 8'h01, !SAT,  0,   1);
        addVec(0, 0, 1, 0, 8'h00, SAT ? 8'h99 : 8'h01, 0,     0,   0);
        addVec(0, 0, 0, 1, 8'h01, 8'h01,            0,        0,   0);
        addVec(0, 1, 0, 0, 8'h00, SAT ? 8'h01 : 8'h99, !SAT,  0,   1);
        addVec(0, 0, 0, 1, 8'h10, 8'h10,            0,        0,   0);
        addVec(0, 1, 0, 0, 8'h00, 8'h09,            0,        0,   0);
        addVec(0, 0, 0, 1, 8'h9A, 8'h09,            0,        1,   0);
        addVec(0, 0, 0, 0, 8'h00, 8'h09,            0,        0,   0);
        addVec(0, 0, 0, 1, 8'h00, 8'h09,            0,        1,   0);
        addVec(0, 0, 0, 1, 8'h42, 8'h42,            0,        0,   0);
        addVec(1, 1, 1, 1, 8'h77, 8'h01,            0,        0,   0);
        addVec(0, 1, 1, 1, 8'h55, 8'h55,            0,        0,   0);
        addVec(0, 0, 1, 1, 8'h99, 8'h99,            0,        0,   0);
        addVec(0, 1, 1, 1, 8'h50, 8'h50,            0,        0,   1);
        addVec(0, 0, 1, 1, 8'hA5, 8'h50,            0,        1,   0);
        addVec(0, 1, 0, 0, 8'h00, 8'h49,            0,        0,   0);
        addVec(0, 1, 1, 0, 8'h00, 8'h50,            0,        0,   0);
        addVec(0, 1, 0, 1, 8'h0F, 8'h50,            0,        1,   0);
        addVec(0, 1, 0, 0, 8'h00, 8'h49,            0,        0,   0);
        addVec(0, 1, 1, 0, 8'h00, 8'h50,            0,        0,   0);

        @(negedge clock);
        foreach (vecs[i]) begin
            applyStimulus(vecs[i], i);
            checkOutput();
        end

        // Three enabled up-steps starting at the top of the window.
        $display("[TB] edge hold/wrap sequence");
        runVec(0, 0, 1, 1, 8'h99, 8'h99, 0, 0, 0, 100);
        runVec(0, 1, 1, 0, 8'h00, SAT ? 8'h99 : 8'h01, !SAT, 0, 1, 101);
        runVec(0, 1, 1, 0, 8'h00, SAT ? 8'h99 : 8'h02, 0, 0, SAT, 102);
        runVec(0, 1, 1, 0, 8'h00, SAT ? 8'h99 : 8'h03, 0, 0, SAT, 103);

        // Rejected load pulse clears after one cycle even if load repeats valid.
        $display("[TB] load_err pulse sequence");
        runVec(0, 0, 1, 1, 8'hF1, SAT ? 8'h99 : 8'h03, 0, 1, 0, 110);
        runVec(0, 0, 1, 1, 8'h20, 8'h20, 0, 0, 0, 111);
        runVec(0, 0, 1, 0, 8'h00, 8'h20, 0, 0, 0, 112);

        // Mid-count reset.
        $display("[TB] mid-count reset sequence");
        runVec(0, 1, 0, 0, 8'h00, 8'h19, 0, 0, 0, 120);
        runVec(1, 1, 0, 0, 8'h00, 8'h01, 0, 0, 0, 121);
        runVec(0, 1, 0, 0, 8'h00, SAT ? 8'h01 : 8'h99, !SAT, 0, 1, 122);

        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL scoreboard_leftover actual=%0d expected=0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
